// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax/argmax datapath: score type, default
// widths, the argmax FSM state encoding and an index-width helper.
package softmax_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NFRAC = 10;

  typedef logic signed [DEF_WIDTH-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare-and-select: keeps (best, idx) unless the candidate is
// strictly greater, so ties stay with the earlier (lower) index.
module argmax_cmp
  import softmax_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = 4
) (
  input  logic signed [WIDTH-1:0] i_best,
  input  logic        [IDX_W-1:0] i_best_idx,
  input  logic signed [WIDTH-1:0] i_cand,
  input  logic        [IDX_W-1:0] i_cand_idx,
  output logic signed [WIDTH-1:0] o_best,
  output logic        [IDX_W-1:0] o_best_idx
);

  logic w_take;

  // Strict signed greater-than selects the candidate.
  always_comb begin
    w_take     = (i_cand > i_best);
    o_best     = w_take ? i_cand : i_best;
    o_best_idx = w_take ? i_cand_idx : i_best_idx;
  end

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over an N-entry score vector: one comparison per cycle,
// result held until the consumer takes it.
// Optional feature: define ARGMAX_THRESH_EN to add the registered lowConf
// output (winning score below THRESH).
module argmax_classifier
  import softmax_pkg::*;
#(
  parameter int unsigned              N      = 10,
  parameter int unsigned              WIDTH  = DEF_WIDTH,
  parameter int unsigned              NFRAC  = DEF_NFRAC,
  parameter logic signed [WIDTH-1:0]  THRESH = 16'sd512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [WIDTH-1:0]       dataIn [N],
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [idx_width(N)-1:0]       classIdx,
  output logic signed [WIDTH-1:0]       classProb
`ifdef ARGMAX_THRESH_EN
  ,
  output logic                          lowConf
`endif
);

  localparam int unsigned        IDX_W    = idx_width(N);
  localparam logic [IDX_W-1:0]   LAST_PTR = IDX_W'(N - 1);

  argmax_state_e             r_state, w_state_d;
  logic signed [WIDTH-1:0]   r_vec [N];
  logic signed [WIDTH-1:0]   r_best, w_best_d, w_cmp_best;
  logic        [IDX_W-1:0]   r_idx, w_idx_d, w_cmp_idx;
  logic        [IDX_W-1:0]   r_ptr, w_ptr_d;
  logic                      w_load;

  argmax_cmp #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_cmp (
    .i_best     (r_best),
    .i_best_idx (r_idx),
    .i_cand     (r_vec[r_ptr]),
    .i_cand_idx (r_ptr),
    .o_best     (w_cmp_best),
    .o_best_idx (w_cmp_idx)
  );

  // Next-state and datapath control.
  always_comb begin
    w_state_d = r_state;
    w_best_d  = r_best;
    w_idx_d   = r_idx;
    w_ptr_d   = r_ptr;
    w_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load    = 1'b1;
          w_best_d  = dataIn[0];
          w_idx_d   = '0;
          w_ptr_d   = IDX_W'(1);
          w_state_d = (N > 1) ? SCAN : DONE;
        end
      end
      SCAN: begin
        w_best_d = w_cmp_best;
        w_idx_d  = w_cmp_idx;
        w_ptr_d  = r_ptr + IDX_W'(1);
        if (r_ptr == LAST_PTR) begin
          w_state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // FSM state and running best/index/pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_best  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_best  <= w_best_d;
      r_idx   <= w_idx_d;
      r_ptr   <= w_ptr_d;
    end
  end

  // Vector snapshot taken at acceptance; later dataIn changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N); i++) begin
        r_vec[i] <= '0;
      end
    end else if (w_load) begin
      r_vec <= dataIn;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign classIdx  = r_idx;
  assign classProb = r_best;

`ifdef ARGMAX_THRESH_EN
  logic r_low_conf;
  logic w_best_upd;

  assign w_best_upd = w_load || (r_state == SCAN);

  // Flag follows the running best so it is final on the same edge as classProb.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_low_conf <= 1'b0;
    end else if (w_best_upd) begin
      r_low_conf <= (w_best_d < THRESH);
    end
  end

  assign lowConf = r_low_conf;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier (N=4, WIDTH=16) using a scoreboard
// queue. Exercises lowConf as well when ARGMAX_THRESH_EN is defined.
module tb_argmax_classifier;
  import softmax_pkg::*;

  localparam int unsigned            N  = 4;
  localparam int unsigned            W  = 16;
  localparam logic signed [W-1:0]    TH = 16'sd512;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic signed [W-1:0]   dataIn [N];
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [1:0]            classIdx;
  logic signed [W-1:0]   classProb;
  logic                  w_low;

  typedef struct {
    logic [1:0]          idx;
    logic signed [15:0]  prob;
    logic                low;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  argmax_classifier #(
    .N      (N),
    .WIDTH  (W),
    .NFRAC  (10),
    .THRESH (TH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (dataIn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .classIdx  (classIdx),
    .classProb (classProb)
`ifdef ARGMAX_THRESH_EN
    ,
    .lowConf   (w_low)
`endif
  );

`ifndef ARGMAX_THRESH_EN
  assign w_low = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  function automatic logic exp_low(input logic signed [W-1:0] p);
`ifdef ARGMAX_THRESH_EN
    return (p < TH);
`else
    return 1'b0;
`endif
  endfunction

  // Reference argmax: first strictly-greater entry wins.
  function automatic exp_t model(input logic signed [W-1:0] a, b, c, d);
    logic signed [W-1:0] v [4];
    exp_t r;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    r.idx  = 2'd0;
    r.prob = a;
    for (int i = 1; i < 4; i++) begin
      if (v[i] > r.prob) begin
        r.prob = v[i];
        r.idx  = 2'(i);
      end
    end
    r.low = exp_low(r.prob);
    return r;
  endfunction

  task automatic push_exp(input logic [1:0] idx, input logic signed [W-1:0] prob);
    exp_t e;
    e.idx  = idx;
    e.prob = prob;
    e.low  = exp_low(prob);
    sb.push_back(e);
  endtask

  // Present one vector for one cycle, then scramble dataIn.
  task automatic send(input logic signed [W-1:0] a, b, c, d);
    @(negedge clk);
    dataIn[0] = a; dataIn[1] = b; dataIn[2] = c; dataIn[3] = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) dataIn[i] = W'($urandom);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 20);
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) dataIn[i] = '0;
    #1 reset = 1'b0;
    #2;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    total++;
    if (classIdx !== 2'd0 || classProb !== 16'sd0 || w_low !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: got idx=%0d prob=%0d low=%b, want 0 0 0",
               classIdx, classProb, w_low);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || w_low !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got in_ready=%b out_valid=%b low=%b, want 1 0 0",
               in_ready, out_valid, w_low);
    end
  endtask

  task automatic test_peaked();
    exp_t e;
    int   cyc;
    push_exp(2'd1, 16'sd717);
    send(16'sd102, 16'sd717, 16'sd102, 16'sd102);
    wait_out(cyc);
    total++;
    if (cyc !== 3) begin
      bad++;
      $display("FAIL latency_peaked: got %0d cycles, want 3", cyc);
    end
    e = sb.pop_front();
    total++;
    if ({classIdx, classProb, w_low} !== {e.idx, e.prob, e.low}) begin
      bad++;
      $display("FAIL result_peaked: got idx=%0d prob=%0d low=%b, want idx=%0d prob=%0d low=%b",
               classIdx, classProb, w_low, e.idx, e.prob, e.low);
    end
    handoff();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_peaked: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_tie();
    exp_t e;
    int   cyc;
    push_exp(2'd0, 16'sd256);
    send(16'sd256, 16'sd256, 16'sd256, 16'sd256);
    wait_out(cyc);
    e = sb.pop_front();
    total++;
    if (cyc !== 3 || {classIdx, classProb, w_low} !== {e.idx, e.prob, e.low}) begin
      bad++;
      $display("FAIL result_tie: got cyc=%0d idx=%0d prob=%0d low=%b, want 3 %0d %0d %b",
               cyc, classIdx, classProb, w_low, e.idx, e.prob, e.low);
    end
    handoff();
  endtask

  task automatic test_negative();
    exp_t e;
    int   cyc;
    push_exp(2'd1, -16'sd3);
    send(-16'sd5, -16'sd3, -16'sd9, -16'sd3);
    wait_out(cyc);
    e = sb.pop_front();
    total++;
    if (cyc !== 3 || {classIdx, classProb, w_low} !== {e.idx, e.prob, e.low}) begin
      bad++;
      $display("FAIL result_neg: got cyc=%0d idx=%0d prob=%0d low=%b, want 3 %0d %0d %b",
               cyc, classIdx, classProb, w_low, e.idx, e.prob, e.low);
    end
    handoff();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   cyc;
    push_exp(2'd2, 16'sd900);
    send(16'sd100, -16'sd200, 16'sd900, 16'sd899);
    wait_out(cyc);
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {classIdx, classProb, w_low} !== {e.idx, e.prob, e.low}) begin
        bad++;
        $display("FAIL hold_%0d: got v=%b r=%b idx=%0d prob=%0d low=%b, want 1 0 %0d %0d %b",
                 k, out_valid, in_ready, classIdx, classProb, w_low, e.idx, e.prob, e.low);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) dataIn[i] = 16'sd30000;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    handoff();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int   cyc;
    int   seen;
    send(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || classIdx !== 2'd0 ||
        classProb !== 16'sd0 || w_low !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got v=%b r=%b idx=%0d prob=%0d low=%b, want 0 1 0 0 0",
               out_valid, in_ready, classIdx, classProb, w_low);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_output: got %0d valid cycles, want 0", seen);
    end
    push_exp(2'd1, -16'sd1);
    send(-16'sd7, -16'sd1, -16'sd4, -16'sd1);
    wait_out(cyc);
    e = sb.pop_front();
    total++;
    if (cyc !== 3 || {classIdx, classProb, w_low} !== {e.idx, e.prob, e.low}) begin
      bad++;
      $display("FAIL after_reset: got cyc=%0d idx=%0d prob=%0d low=%b, want 3 %0d %0d %b",
               cyc, classIdx, classProb, w_low, e.idx, e.prob, e.low);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] v [4];
    exp_t e;
    int   cyc;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (t % 3 == 0) v[i] = W'(int'($urandom_range(0, 6)) - 3);
        else            v[i] = W'($urandom);
      end
      sb.push_back(model(v[0], v[1], v[2], v[3]));
      send(v[0], v[1], v[2], v[3]);
      wait_out(cyc);
      e = sb.pop_front();
      total++;
      if (cyc !== 3 || {classIdx, classProb, w_low} !== {e.idx, e.prob, e.low}) begin
        bad++;
        $display("FAIL rand_%0d: got cyc=%0d idx=%0d prob=%0d low=%b, want 3 %0d %0d %b",
                 t, cyc, classIdx, classProb, w_low, e.idx, e.prob, e.low);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      handoff();
    end
  endtask

`ifdef ARGMAX_THRESH_EN
  task automatic test_thresh();
    int cyc;
    send(16'sd100, 16'sd400, -16'sd50, 16'sd399);
    wait_out(cyc);
    total++;
    if (w_low !== 1'b1 || classProb !== 16'sd400) begin
      bad++;
      $display("FAIL thresh_400: got low=%b prob=%0d, want 1 400", w_low, classProb);
    end
    handoff();
    send(16'sd600, 16'sd100, 16'sd599, 16'sd0);
    wait_out(cyc);
    total++;
    if (w_low !== 1'b0 || classProb !== 16'sd600) begin
      bad++;
      $display("FAIL thresh_600: got low=%b prob=%0d, want 0 600", w_low, classProb);
    end
    handoff();
  endtask
`endif

  initial begin
    test_reset();
    test_peaked();
    test_tie();
    test_negative();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
`ifdef ARGMAX_THRESH_EN
    test_thresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
